memory_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared memory port in the multicycle core. Requester 0 is instruction fetch (read-only); requester 1 is load/store (read or write). The block picks one requester using round-robin on ties and drives the `Selector_i` of the 2-to-1 address/data multiplexers in front of the memory. It then holds the memory enable for a fixed number of cycles and returns a one-cycle completion pulse to the winner.

---
 rtl/memory_port_arbiter.sv | 131 +++++++++++++
 tb/tb_memory_port_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Purpose: round-robin arbiter and sequencer for the shared memory port (fetch vs load/store).
// Latency: grant registered one edge after request; Mem_En_o held MEM_LATENCY cycles; Done pulse follows.
// Backpressure: requesters hold Req until their Done pulse; the port takes one access per MEM_LATENCY+2 cycles.
module memory_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_BITS    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic Req0_i,
    input  logic Req1_i,
    input  logic Write1_i,
    output logic Gnt0_o,
    output logic Gnt1_o,
    output logic Done0_o,
    output logic Done1_o,
    output logic Mux_Sel_o,
    output logic Mem_En_o,
    output logic Mem_Write_o,
    output logic Busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MEM_LATENCY - 1);

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] cnt, cnt_nxt;
    logic                last, last_nxt;
    logic                winner;
    logic                gnt0_nxt, gnt1_nxt;
    logic                done0_nxt, done1_nxt;
    logic                mux_sel_nxt, mem_en_nxt, mem_write_nxt, busy_nxt;

    // State, counter, round-robin pointer and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 1'b1;
            Gnt0_o      <= 1'b0;
            Gnt1_o      <= 1'b0;
            Done0_o     <= 1'b0;
            Done1_o     <= 1'b0;
            Mux_Sel_o   <= 1'b0;
            Mem_En_o    <= 1'b0;
            Mem_Write_o <= 1'b0;
            Busy_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last        <= last_nxt;
            Gnt0_o      <= gnt0_nxt;
            Gnt1_o      <= gnt1_nxt;
            Done0_o     <= done0_nxt;
            Done1_o     <= done1_nxt;
            Mux_Sel_o   <= mux_sel_nxt;
            Mem_En_o    <= mem_en_nxt;
            Mem_Write_o <= mem_write_nxt;
            Busy_o      <= busy_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition changes it.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_nxt      = last;
        gnt0_nxt      = Gnt0_o;
        gnt1_nxt      = Gnt1_o;
        done0_nxt     = Done0_o;
        done1_nxt     = Done1_o;
        mux_sel_nxt   = Mux_Sel_o;
        mem_en_nxt    = Mem_En_o;
        mem_write_nxt = Mem_Write_o;
        // On a tie the requester that was not served last wins; otherwise the lone requester.
        winner        = (Req0_i && Req1_i) ? ~last : Req1_i;

        case (state)
            IDLE: begin
                if (Req0_i || Req1_i) begin
                    state_nxt     = BUSY;
                    gnt0_nxt      = ~winner;
                    gnt1_nxt      = winner;
                    mux_sel_nxt   = winner;
                    mem_en_nxt    = 1'b1;
                    // Write intent is captured only here; later changes cannot affect this access.
                    mem_write_nxt = winner & Write1_i;
                    cnt_nxt       = CNT_LOAD;
                    last_nxt      = winner;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_BITS'(1);
                end else begin
                    // Access cannot be aborted, so Done fires even if Req dropped meanwhile.
                    state_nxt     = DONE;
                    mem_en_nxt    = 1'b0;
                    mem_write_nxt = 1'b0;
                    done0_nxt     = Gnt0_o;
                    done1_nxt     = Gnt1_o;
                end
            end
            DONE: begin
                // Requests are deliberately not looked at here; a held Req is seen next cycle in IDLE.
                state_nxt = IDLE;
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
                done0_nxt = 1'b0;
                done1_nxt = 1'b0;
            end
            default: begin
                state_nxt     = IDLE;
                gnt0_nxt      = 1'b0;
                gnt1_nxt      = 1'b0;
                done0_nxt     = 1'b0;
                done1_nxt     = 1'b0;
                mem_en_nxt    = 1'b0;
                mem_write_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, write1;
    logic [NI-1:0] gnt0, gnt1, done0, done1, mux, en, wr, busy;

    int checks = 0;
    int errors = 0;

    // Instance 0 uses the default latency, instance 1 the minimum latency.
    memory_port_arbiter #(.MEM_LATENCY(2), .CNT_BITS(4)) u_dut_l2 (
        .clk(clk), .reset(reset), .Req0_i(req0), .Req1_i(req1), .Write1_i(write1),
        .Gnt0_o(gnt0[0]), .Gnt1_o(gnt1[0]), .Done0_o(done0[0]), .Done1_o(done1[0]),
        .Mux_Sel_o(mux[0]), .Mem_En_o(en[0]), .Mem_Write_o(wr[0]), .Busy_o(busy[0])
    );

    memory_port_arbiter #(.MEM_LATENCY(1), .CNT_BITS(4)) u_dut_l1 (
        .clk(clk), .reset(reset), .Req0_i(req0), .Req1_i(req1), .Write1_i(write1),
        .Gnt0_o(gnt0[1]), .Gnt1_o(gnt1[1]), .Done0_o(done0[1]), .Done1_o(done1[1]),
        .Mux_Sel_o(mux[1]), .Mem_En_o(en[1]), .Mem_Write_o(wr[1]), .Busy_o(busy[1])
    );

    always #5 clk = ~clk;

    // Reference model: an access is described by its owner and its age in cycles since the grant.
    int   m_owner [NI];
    int   m_age   [NI];
    logic m_last  [NI];
    logic m_mux   [NI];
    logic m_wr    [NI];

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_owner[i] = -1;
            m_age[i]   = 0;
            m_last[i]  = 1'b1;
            m_mux[i]   = 1'b0;
            m_wr[i]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic w;
        for (int i = 0; i < NI; i++) begin
            if (m_owner[i] >= 0) begin
                // Ages 0..L-1 are enable cycles, age L is the Done cycle, then back to idle.
                if (m_age[i] == lat(i)) m_owner[i] = -1;
                else                    m_age[i]++;
            end else if (req0 || req1) begin
                if (req0 && req1) w = ~m_last[i];
                else              w = req1;
                m_owner[i] = w ? 1 : 0;
                m_age[i]   = 0;
                m_last[i]  = w;
                m_mux[i]   = w;
                m_wr[i]    = w & write1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic act, en_e, done_e;
        for (int i = 0; i < NI; i++) begin
            act    = (m_owner[i] >= 0);
            en_e   = act && (m_age[i] < lat(i));
            done_e = act && (m_age[i] == lat(i));
            check($sformatf("%s_L%0d_gnt0", ph, lat(i)),  gnt0[i],  act && m_owner[i] == 0);
            check($sformatf("%s_L%0d_gnt1", ph, lat(i)),  gnt1[i],  act && m_owner[i] == 1);
            check($sformatf("%s_L%0d_done0", ph, lat(i)), done0[i], done_e && m_owner[i] == 0);
            check($sformatf("%s_L%0d_done1", ph, lat(i)), done1[i], done_e && m_owner[i] == 1);
            check($sformatf("%s_L%0d_mux", ph, lat(i)),   mux[i],   m_mux[i]);
            check($sformatf("%s_L%0d_en", ph, lat(i)),    en[i],    en_e);
            check($sformatf("%s_L%0d_wr", ph, lat(i)),    wr[i],    en_e && m_wr[i]);
            check($sformatf("%s_L%0d_busy", ph, lat(i)),  busy[i],  act);
            check($sformatf("%s_L%0d_gnt_excl", ph, lat(i)), gnt0[i] & gnt1[i], 1'b0);
            check($sformatf("%s_L%0d_done_en", ph, lat(i)), (done0[i] | done1[i]) & en[i], 1'b0);
        end
    endtask

    // One clock: advance the model at the rising edge, compare on the falling edge.
    task automatic step(input string ph);
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        reset  = 1'b0;
        req0   = 1'b1;
        req1   = 1'b1;
        write1 = 1'b0;
        model_reset();

        // Reset held with both requests up: everything stays at zero.
        repeat (3) step("reset");

        // Release; both held high gives alternating grants starting with requester 0.
        reset = 1'b1;
        repeat (20) step("rr");

        // Random requests, drops and write toggles, including changes after grant.
        for (int n = 0; n < 400; n++) begin
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 3) != 0);
            write1 = $urandom_range(0, 1);
            step("rand");
        end

        // Well-behaved requesters: hold Req until Done, then maybe request again.
        for (int n = 0; n < 200; n++) begin
            if (done0[0]) req0 = $urandom_range(0, 1);
            else if (!req0) req0 = $urandom_range(0, 1);
            if (done1[0]) req1 = $urandom_range(0, 1);
            else if (!req1) req1 = $urandom_range(0, 1);
            write1 = $urandom_range(0, 1);
            step("hs");
        end

        // Drain to idle, then start a fetch and reset during its second busy cycle.
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (6) step("drain");
        req0 = 1'b1;
        step("pre_rst");
        step("pre_rst");
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("midrst");
        step("midrst_hold");

        // After reset the tie must again go to requester 0.
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        repeat (12) step("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
